// File: rtl/csr_ctrl_pkg.sv
// Shared types and constants for the CSR access controller and the
// privilege-check stage that feeds it.
package csr_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACCESS  = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_RESP    = 3'd3,
    ST_TRAP    = 3'd4
  } state_e;

  localparam int unsigned CAUSE_ILLEGAL_CSR   = 32'd2;
  localparam logic [1:0]  EXPECTED_PRIV_LEVEL = 2'b11;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_SATP    = 12'h180;

  // Address bits [9:8] encode the lowest privilege level allowed to touch the CSR.
  function automatic logic is_machine_csr(input logic [11:0] addr);
    return (addr[9:8] == EXPECTED_PRIV_LEVEL);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/csr_access_ctrl.sv
// One-request-at-a-time CSR access stage: forwards legal requests to the CSR
// file, turns privilege violations into a held trap plus flush pulse.
module csr_access_ctrl
  import csr_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 8,
  parameter int CAUSE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               csr_we,
  input  logic               csr_read,
  input  logic [ADDR_W-1:0]  csr_addr,
  input  logic [DATA_W-1:0]  csr_wdata,
  input  logic               exception_i,
  output logic               csr_file_en,
  output logic               csr_file_we,
  output logic [ADDR_W-1:0]  csr_file_addr,
  output logic [DATA_W-1:0]  csr_file_wdata,
  input  logic [DATA_W-1:0]  csr_file_rdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATA_W-1:0]  rsp_rdata,
  output logic               rsp_error,
  output logic               trap_valid,
  input  logic               trap_ack,
  output logic [CAUSE_W-1:0] trap_cause,
  output logic [DATA_W-1:0]  trap_tval,
  output logic               flush,
  output logic [CNT_W-1:0]   fault_count
);

  state_e              state_q;
  logic                cap_read_q;
  logic [ADDR_W-1:0]   cap_addr_q;
  logic [DATA_W-1:0]   cap_wdata_q;
  logic                req_ready_q;
  logic                file_en_q;
  logic                file_we_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                rsp_error_q;
  logic                trap_valid_q;
  logic [CAUSE_W-1:0]  trap_cause_q;
  logic [DATA_W-1:0]   trap_tval_q;
  logic                flush_q;
  logic                fault_s;

  assign fault_s = (state_q == ST_IDLE) && req_valid && exception_i && (csr_we || csr_read);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cap_read_q   <= 1'b0;
      cap_addr_q   <= '0;
      cap_wdata_q  <= '0;
      req_ready_q  <= 1'b1;
      file_en_q    <= 1'b0;
      file_we_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_error_q  <= 1'b0;
      trap_valid_q <= 1'b0;
      trap_cause_q <= '0;
      trap_tval_q  <= '0;
      flush_q      <= 1'b0;
    end else begin
      file_en_q <= 1'b0;
      file_we_q <= 1'b0;
      flush_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            cap_read_q  <= csr_read;
            cap_addr_q  <= csr_addr;
            cap_wdata_q <= csr_wdata;
            req_ready_q <= 1'b0;
            if (exception_i && (csr_we || csr_read)) begin
              state_q      <= ST_TRAP;
              trap_valid_q <= 1'b1;
              trap_cause_q <= CAUSE_W'(CAUSE_ILLEGAL_CSR);
              trap_tval_q  <= DATA_W'(csr_addr);
              flush_q      <= 1'b1;
            end else if (csr_we || csr_read) begin
              state_q   <= ST_ACCESS;
              file_en_q <= 1'b1;
              file_we_q <= csr_we;
            end else begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= '0;
              rsp_error_q <= 1'b0;
            end
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        ST_ACCESS: begin
          state_q <= ST_CAPTURE;
        end
        // The file presents read data in the cycle after its strobe.
        ST_CAPTURE: begin
          state_q     <= ST_RESP;
          rsp_valid_q <= 1'b1;
          rsp_error_q <= 1'b0;
          rsp_rdata_q <= cap_read_q ? csr_file_rdata : '0;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
          end else begin
            state_q <= ST_RESP;
          end
        end
        ST_TRAP: begin
          if (trap_ack) begin
            state_q      <= ST_RESP;
            trap_valid_q <= 1'b0;
            trap_cause_q <= '0;
            trap_tval_q  <= '0;
            rsp_valid_q  <= 1'b1;
            rsp_rdata_q  <= '0;
            rsp_error_q  <= 1'b1;
          end else begin
            state_q <= ST_TRAP;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          req_ready_q  <= 1'b1;
          rsp_valid_q  <= 1'b0;
          trap_valid_q <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_fault_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (fault_s),
    .count (fault_count)
  );

  assign req_ready      = req_ready_q;
  assign csr_file_en    = file_en_q;
  assign csr_file_we    = file_we_q;
  assign csr_file_addr  = cap_addr_q;
  assign csr_file_wdata = cap_wdata_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_error      = rsp_error_q;
  assign trap_valid     = trap_valid_q;
  assign trap_cause     = trap_cause_q;
  assign trap_tval      = trap_tval_q;
  assign flush          = flush_q;

endmodule
